vga_fb_draw: RTL and testbench
==============================

// Module: vga_fb_draw
// PURPOSE
//  Pixel-source end of the VGA display path: owns a down-scaled 12-bit framebuffer and a drawing engine.
//  CPU-side MMIO logic issues PLOT/FILL/CLEAR commands over a valid/ready handshake.
//  The scan side presents row/col and receives the RRRR_GGGG_BBBB pixel word for the VGA output driver.
//  Runs entirely on the 100 MHz system clock; the scan side samples its output at the 25 MHz pixel rate.
// PARAMETERS
//  FB_W        160  framebuffer width in pixels (screen col >> SCALE_SH)
//  FB_H        120  framebuffer height in pixels (screen row >> SCALE_SH)
//  SCALE_SH    2    log2 of the screen-to-framebuffer scale factor (640x480 -> 160x120)
//  ADDR_W      15   framebuffer address width, must satisfy 2**ADDR_W >= FB_W*FB_H
// PORTS
//  clk        in   1   system clock, 100 MHz
//  rst        in   1   synchronous, active-high reset
//  row        in   9   scan row, 0..479
//  col        in   10  scan column, 0..639
//  pixel      out  12  framebuffer colour at (row,col), RRRR_GGGG_BBBB
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   engine can accept a command
//  cmd_op     in   2   0=PLOT, 1=FILL, 2=CLEAR, 3=reserved (treated as NOP)
//  cmd_x0     in   8   start x (framebuffer coordinates)
//  cmd_y0     in   7   start y
//  cmd_x1     in   8   end x, inclusive (FILL only)
//  cmd_y1     in   7   end y, inclusive (FILL only)
//  cmd_color  in   12  colour to write
//  busy       out  1   engine is executing a command
//  done       out  1   one-cycle pulse when a command completes
// BEHAVIOUR
//  Reset values: cmd_ready=1, busy=0, done=0, pixel=12'h000. Framebuffer contents are not cleared by rst.
//  Read path:
//   - addr = (row>>SCALE_SH)*FB_W + (col>>SCALE_SH).
//   - pixel is valid 2 clk cycles after row/col change (address register, then RAM output register).
//   - row>=480 or col>=640 -> pixel=0.
//  Handshake:
//   - Command is accepted on the cycle where cmd_valid & cmd_ready are both high; operands are latched.
//   - cmd_ready=0 from the cycle after acceptance until the cycle after done.
//  FSM states:
//   - IDLE: on accept, go to PLOT (op 0), FILL (op 1/2) or DONE (op 3).
//   - PLOT: one write, then DONE.
//   - FILL: writes one pixel per cycle, x inner loop, y outer loop; after the last pixel, go to DONE.
//   - DONE: done=1 for exactly one cycle, then IDLE.
//  CLEAR is FILL with x0=0, y0=0, x1=FB_W-1, y1=FB_H-1; supplied coordinates are ignored.
//  Clipping:
//   - x1/y1 above FB_W-1/FB_H-1 are clamped.
//   - PLOT with x0>=FB_W or y0>=FB_H performs no write.
//   - FILL with x0>x1 or y0>y1 (after clamping) performs zero writes.
//   - Every clipped or empty case still passes through DONE.
//  Write address uses a constant multiply, y*FB_W; products are ADDR_W wide.
//  Write latency: PLOT write occurs 1 cycle after acceptance; done follows 1 cycle later.
//   A full FILL of w*h pixels gives done exactly w*h+1 cycles after acceptance.
//  Read/write to the same address in the same cycle: the read returns the old data (read-first).
//  busy=1 in PLOT/FILL/DONE, 0 in IDLE.
//  Reset during a FILL aborts it: remaining pixels are not written, no done pulse is produced,
//   and cmd_ready=1 on the first cycle after rst deasserts.
//  cmd_valid while busy is ignored; the command is not queued.
// STRUCTURE
//  vga_fb_defs.vh: FB_W, FB_H, SCALE_SH, ADDR_W defaults, op codes (OP_PLOT/OP_FILL/OP_CLEAR), FSM state encodings.
//  Sub-module vga_fb_ram: simple dual-port RAM, FB_W*FB_H x 12.
//   - One synchronous write port, one registered read port, read-first, infers block RAM.
//  Top level holds the FSM, x/y counters, clipping logic and read address generation.
// TESTING
//  1. PLOT (10,20) colour 12'hF00, then scan row=80,col=40..43 -> pixel=12'hF00 two cycles later; col=44 -> prior value.
//  2. FILL (0,0)-(3,1) 12'h0F0 -> exactly 8 writes, done 9 cycles after accept; (4,0) unchanged.
//  3. CLEAR 12'h00F -> done 19201 cycles after accept; random row/col reads return 12'h00F.
//  4. FILL (150,110)-(200,127) 12'hFFF -> clamped to 10x10 = 100 writes; FILL x0=5,x1=3 -> 0 writes, done 1 cycle after accept.
//  5. rst asserted mid-CLEAR at pixel 500 -> no done pulse, pixels 500+ keep old colour, cmd_ready=1 after rst drops.
//  6. cmd_valid held high while busy -> only the first command executes; row=480 -> pixel=0.

Source files
------------

// File: rtl/vga_fb_draw_pkg.sv
// Shared definitions for the VGA framebuffer drawing block.
//  - Default framebuffer geometry and address width.
//  - Command op codes seen on cmd_op.
//  - Drawing-engine FSM state encoding.
//  - Small clamp helpers used when latching FILL end coordinates.
package vga_fb_draw_pkg;

  // Default geometry: 640x480 screen shown from a 160x120 framebuffer.
  localparam int FB_W_DEF     = 160;
  localparam int FB_H_DEF     = 120;
  localparam int SCALE_SH_DEF = 2;
  localparam int ADDR_W_DEF   = 15;

  // Command op codes.
  localparam logic [1:0] OP_PLOT  = 2'd0;
  localparam logic [1:0] OP_FILL  = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;
  localparam logic [1:0] OP_NOP   = 2'd3;

  // Drawing-engine states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLOT = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } fsm_state_t;

  // Saturate an x coordinate to the last framebuffer column.
  function automatic logic [7:0] clamp_x(input logic [7:0] v, input logic [7:0] vmax);
    return (v > vmax) ? vmax : v;
  endfunction

  // Saturate a y coordinate to the last framebuffer row.
  function automatic logic [6:0] clamp_y(input logic [6:0] v, input logic [6:0] vmax);
    return (v > vmax) ? vmax : v;
  endfunction

endpackage

// File: rtl/vga_fb_draw_ram.sv
// Simple dual-port framebuffer RAM.
//  - One synchronous write port and one registered read port on the same clock.
//  - Read-first: a read and a write to the same address in one cycle
//    returns the data held before the write.
//  - Contents are never reset, so the array maps onto block RAM.
// Ports:
//  clk      in   system clock
//  i_we     in   write enable
//  i_waddr  in   write address
//  i_wdata  in   write data
//  i_raddr  in   read address
//  o_rdata  out  registered read data (one cycle after i_raddr)
module vga_fb_draw_ram #(
  parameter int DEPTH  = 19200,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] r_rdata;

  // Write and read share one process: the read samples the array before
  // the non-blocking write lands, which gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
    r_rdata <= mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/vga_fb_draw.sv
// Pixel source for the VGA display path: a down-scaled 12-bit framebuffer
// plus a drawing engine that executes PLOT / FILL / CLEAR commands.
// Ports:
//  clk        in   system clock (100 MHz)
//  rst        in   synchronous active-high reset
//  row, col   in   scan position on the 640x480 screen
//  pixel      out  RRRR_GGGG_BBBB colour at (row,col), two cycles after row/col
//  cmd_valid  in   command present
//  cmd_ready  out  engine idle and able to take a command
//  cmd_op     in   0=PLOT, 1=FILL, 2=CLEAR, 3=NOP
//  cmd_x0/y0  in   start coordinate (framebuffer space)
//  cmd_x1/y1  in   inclusive end coordinate (FILL only)
//  cmd_color  in   colour to write
//  busy       out  engine executing a command
//  done       out  one-cycle pulse when a command completes
module vga_fb_draw
  import vga_fb_draw_pkg::*;
#(
  parameter int FB_W     = FB_W_DEF,
  parameter int FB_H     = FB_H_DEF,
  parameter int SCALE_SH = SCALE_SH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  row,
  input  logic [9:0]  col,
  output logic [11:0] pixel,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_x0,
  input  logic [6:0]  cmd_y0,
  input  logic [7:0]  cmd_x1,
  input  logic [6:0]  cmd_y1,
  input  logic [11:0] cmd_color,
  output logic        busy,
  output logic        done
);

  localparam int                DEPTH    = FB_W * FB_H;
  localparam logic [7:0]        X_MAX    = 8'(FB_W - 1);
  localparam logic [6:0]        Y_MAX    = 7'(FB_H - 1);
  localparam logic [8:0]        ROW_LIM  = 9'(FB_H << SCALE_SH);
  localparam logic [9:0]        COL_LIM  = 10'(FB_W << SCALE_SH);
  localparam logic [ADDR_W-1:0] W_STRIDE = ADDR_W'(FB_W);

  // ---------------------------------------------------------------------------
  // Scan-side read path: address register, then the RAM output register.
  // ---------------------------------------------------------------------------
  logic [8:0]        w_row_fb;
  logic [9:0]        w_col_fb;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_vld1;
  logic              r_rd_vld2;
  logic [11:0]       w_ram_q;

  assign w_row_fb   = row >> SCALE_SH;
  assign w_col_fb   = col >> SCALE_SH;
  assign w_in_range = (row < ROW_LIM) && (col < COL_LIM);
  // Off-screen positions read address 0 so the RAM index always stays in
  // range; the in-range flag travels alongside and blanks the result.
  assign w_rd_addr  = w_in_range ? (ADDR_W'(w_row_fb) * W_STRIDE + ADDR_W'(w_col_fb))
                                 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_addr <= '0;
      r_rd_vld1 <= 1'b0;
      r_rd_vld2 <= 1'b0;
    end else begin
      r_rd_addr <= w_rd_addr;
      r_rd_vld1 <= w_in_range;
      r_rd_vld2 <= r_rd_vld1;
    end
  end

  // The valid flag clears on reset, so pixel reads 0 until the pipeline refills.
  assign pixel = r_rd_vld2 ? w_ram_q : 12'h000;

  // ---------------------------------------------------------------------------
  // Command decode at acceptance: CLEAR substitution, clamping, empty test.
  // ---------------------------------------------------------------------------
  logic       w_accept;
  logic [7:0] w_x0;
  logic [6:0] w_y0;
  logic [7:0] w_x1;
  logic [6:0] w_y1;
  logic       w_fill_empty;
  logic       w_plot_ok;

  assign w_accept  = cmd_valid && cmd_ready;
  assign w_plot_ok = (cmd_x0 <= X_MAX) && (cmd_y0 <= Y_MAX);

  always_comb begin
    w_x0 = cmd_x0;
    w_y0 = cmd_y0;
    w_x1 = clamp_x(cmd_x1, X_MAX);
    w_y1 = clamp_y(cmd_y1, Y_MAX);
    if (cmd_op == OP_CLEAR) begin
      w_x0 = '0;
      w_y0 = '0;
      w_x1 = X_MAX;
      w_y1 = Y_MAX;
    end
    // A start beyond the clamped end (including a start past the screen edge)
    // yields an empty rectangle.
    w_fill_empty = (w_x0 > w_x1) || (w_y0 > w_y1);
  end

  // ---------------------------------------------------------------------------
  // Drawing engine FSM with registered handshake/status outputs.
  // ---------------------------------------------------------------------------
  fsm_state_t r_state;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [7:0] r_x0;
  logic [7:0] r_x1;
  logic [6:0] r_y1;
  logic [11:0] r_color;
  logic       r_plot_ok;
  logic       r_ready;
  logic       r_busy;
  logic       r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      // An in-flight FILL is simply dropped; no done pulse is produced.
      r_state   <= ST_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_x0      <= '0;
      r_x1      <= '0;
      r_y1      <= '0;
      r_color   <= '0;
      r_plot_ok <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_x       <= w_x0;
            r_y       <= w_y0;
            r_x0      <= w_x0;
            r_x1      <= w_x1;
            r_y1      <= w_y1;
            r_color   <= cmd_color;
            r_plot_ok <= w_plot_ok;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            case (cmd_op)
              OP_PLOT: r_state <= ST_PLOT;
              OP_FILL, OP_CLEAR: begin
                if (w_fill_empty) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= ST_FILL;
                end
              end
              default: begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end
            endcase
          end
        end
        ST_PLOT: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_FILL: begin
          // x is the inner loop; wrap to the start column at the row end.
          if (r_x == r_x1) begin
            r_x <= r_x0;
            if (r_y == r_y1) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_y <= r_y + 7'd1;
            end
          end else begin
            r_x <= r_x + 8'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;

  // ---------------------------------------------------------------------------
  // Write port: address from the live counters, one pixel per FILL cycle.
  // ---------------------------------------------------------------------------
  logic              w_we;
  logic [ADDR_W-1:0] w_wr_addr;

  // rst blocks the write on the edge that aborts a command, so the pixel
  // that would have been written there keeps its old colour.
  assign w_we      = !rst && ((r_state == ST_FILL) || ((r_state == ST_PLOT) && r_plot_ok));
  assign w_wr_addr = ADDR_W'(r_y) * W_STRIDE + ADDR_W'(r_x);

  vga_fb_draw_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (12)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_wr_addr),
    .i_wdata (r_color),
    .i_raddr (r_rd_addr),
    .o_rdata (w_ram_q)
  );

endmodule

// File: tb/tb_vga_fb_draw.sv
module tb_vga_fb_draw;

  localparam int W = 160;
  localparam int H = 120;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  row = '0;
  logic [9:0]  col = '0;
  logic [11:0] pixel;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [7:0]  cmd_x0 = '0;
  logic [6:0]  cmd_y0 = '0;
  logic [7:0]  cmd_x1 = '0;
  logic [6:0]  cmd_y1 = '0;
  logic [11:0] cmd_color = '0;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  // Reference picture of the framebuffer, indexed y*W + x.
  logic [11:0] model_fb [W*H];

  vga_fb_draw dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .pixel     (pixel),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_x1    (cmd_x1),
    .cmd_y1    (cmd_y1),
    .cmd_color (cmd_color),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Paint the reference picture and return the cycle (counted from the
  // acceptance cycle) in which done is expected.
  function automatic int model_apply(input int op, input int x0, input int y0,
                                     input int x1, input int y1, input logic [11:0] color);
    int xa, ya, xb, yb, n;
    if (op == 3) return 1;
    if (op == 0) begin
      if (x0 < W && y0 < H) model_fb[y0*W + x0] = color;
      return 2;
    end
    if (op == 2) begin
      xa = 0; ya = 0; xb = W-1; yb = H-1;
    end else begin
      xa = x0; ya = y0;
      xb = (x1 > W-1) ? W-1 : x1;
      yb = (y1 > H-1) ? H-1 : y1;
    end
    n = 0;
    for (int y = ya; y <= yb; y++)
      for (int x = xa; x <= xb; x++) begin
        model_fb[y*W + x] = color;
        n++;
      end
    return n + 1;
  endfunction

  function automatic logic [11:0] model_pixel(input int r, input int c);
    if (r >= 4*H || c >= 4*W) return 12'h000;
    return model_fb[(r/4)*W + (c/4)];
  endfunction

  task automatic run_cmd(input int op, input int x0, input int y0, input int x1,
                         input int y1, input logic [11:0] color, input string name);
    int k, exp_k;
    @(negedge clk);
    k = 0;
    while (cmd_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL %s ready_before: got %b want 1", name, cmd_ready);
    end
    cmd_op = 2'(op); cmd_x0 = 8'(x0); cmd_y0 = 7'(y0);
    cmd_x1 = 8'(x1); cmd_y1 = 7'(y1); cmd_color = color; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    exp_k = model_apply(op, x0, y0, x1, y1, color);
    k = 1;
    while (done !== 1'b1 && k < 25000) begin @(posedge clk); #1; k++; end
    n_vec++;
    if (k != exp_k) begin
      n_err++; $display("FAIL %s done_latency: got %0d want %0d", name, k, exp_k);
    end
    n_vec++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL %s done_cycle_status: ready=%b busy=%b want ready=0 busy=1", name, cmd_ready, busy);
    end
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL %s after_done: done=%b ready=%b busy=%b want 0 1 0", name, done, cmd_ready, busy);
    end
    $display("cmd %s op=%0d (%0d,%0d)-(%0d,%0d) col=%h done_at=%0d", name, op, x0, y0, x1, y1, color, k);
  endtask

  task automatic read_check(input int r, input int c, input string name);
    logic [11:0] exp;
    @(negedge clk);
    row = 9'(r); col = 10'(c);
    @(posedge clk); @(posedge clk); #1;
    exp = model_pixel(r, c);
    n_vec++;
    if (pixel !== exp) begin
      n_err++; $display("FAIL %s pixel(row=%0d,col=%0d): got %h want %h", name, r, c, pixel, exp);
    end
  endtask

  task automatic read_random(input int n, input string name);
    for (int i = 0; i < n; i++)
      read_check($urandom_range(0, 479), $urandom_range(0, 639), name);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || pixel !== 12'h000) begin
      n_err++;
      $display("FAIL reset_state: ready=%b busy=%b done=%b pixel=%h want 1 0 0 000", cmd_ready, busy, done, pixel);
    end
    $display("reset checked");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_plot;
    run_cmd(0, 10, 20, 0, 0, 12'hF00, "plot");
    for (int c = 40; c <= 44; c++) read_check(80, c, "plot_scan");
    read_check(83, 43, "plot_scan_corner");
    // Off-screen PLOT: no write, but still completes
    run_cmd(0, 170, 5, 0, 0, 12'h777, "plot_clip_x");
    run_cmd(0, 5, 125, 0, 0, 12'h777, "plot_clip_y");
    read_check(20, 20, "plot_clip_scan");
    run_cmd(3, 1, 1, 5, 5, 12'h999, "nop");
    read_check(4, 4, "nop_scan");
  endtask

  task automatic test_fill_small;
    run_cmd(1, 0, 0, 3, 1, 12'h0F0, "fill_small");
    read_check(0, 0, "fill_small_first");
    read_check(7, 15, "fill_small_last");
    read_check(0, 16, "fill_small_right");
    read_check(8, 0, "fill_small_below");
  endtask

  task automatic test_clear;
    run_cmd(2, 33, 44, 2, 1, 12'h00F, "clear");
    read_random(30, "clear_scan");
    read_check(479, 639, "clear_last");
  endtask

  task automatic test_clip;
    run_cmd(1, 150, 110, 200, 127, 12'hFFF, "fill_clamp");
    read_check(440, 600, "clamp_first");
    read_check(479, 639, "clamp_last");
    read_check(440, 599, "clamp_left");
    read_check(439, 600, "clamp_above");
    run_cmd(1, 5, 2, 3, 9, 12'hABC, "fill_empty_x");
    run_cmd(1, 2, 9, 8, 4, 12'hABC, "fill_empty_y");
    run_cmd(1, 165, 2, 200, 9, 12'hABC, "fill_empty_offscreen");
    read_check(16, 16, "empty_scan");
  endtask

  task automatic test_reset_mid_clear;
    logic saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    cmd_op = 2'd2; cmd_color = 12'hA5A; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    // Pixels 0..499 land on the next 500 edges
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_ready: ready=%b busy=%b want 1 0", cmd_ready, busy);
    end
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_vec++;
    if (saw_done !== 1'b0) begin
      n_err++; $display("FAIL abort_done: got %b want 0", saw_done);
    end
    for (int i = 0; i < 500; i++) model_fb[i] = 12'hA5A;
    $display("cmd clear aborted after 500 pixels");
    read_check(12, 76, "abort_pix499");
    read_check(12, 80, "abort_pix500");
    read_check(0, 0, "abort_pix0");
    read_check(479, 639, "abort_last");
    read_random(20, "abort_scan");
  endtask

  task automatic test_busy_ignore;
    int k;
    @(negedge clk);
    cmd_op = 2'd1; cmd_x0 = 8'd20; cmd_y0 = 7'd30; cmd_x1 = 8'd23; cmd_y1 = 7'd30;
    cmd_color = 12'h0AB; cmd_valid = 1'b1;
    @(posedge clk); #1;
    // A second command stays asserted while the engine is busy
    cmd_op = 2'd0; cmd_x0 = 8'd100; cmd_y0 = 7'd100; cmd_color = 12'hEEE;
    k = 1;
    while (done !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
    cmd_valid = 1'b0;
    n_vec++;
    if (k != model_apply(1, 20, 30, 23, 30, 12'h0AB)) begin
      n_err++; $display("FAIL busy_latency: got %0d want 5", k);
    end
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL busy_after: busy=%b ready=%b want 0 1", busy, cmd_ready);
    end
    $display("cmd busy_ignore fill done_at=%0d", k);
    read_check(400, 400, "busy_second_not_run");
    read_check(120, 80, "busy_fill_first");
    read_check(123, 95, "busy_fill_last");
    read_check(480, 10, "row_480");
    read_check(10, 640, "col_640");
    read_check(511, 1023, "row_col_max");
  endtask

  task automatic test_random;
    int op, x0, y0, x1, y1;
    for (int i = 0; i < 25; i++) begin
      op = $urandom_range(0, 3);
      if (op == 2) op = 1;
      x0 = $urandom_range(0, 175);
      y0 = $urandom_range(0, 127);
      x1 = x0 + $urandom_range(0, 30) - 3;
      y1 = y0 + $urandom_range(0, 30) - 3;
      if (x1 < 0) x1 = 0;
      if (x1 > 255) x1 = 255;
      if (y1 < 0) y1 = 0;
      if (y1 > 127) y1 = 127;
      run_cmd(op, x0, y0, x1, y1, 12'($urandom), "random");
      read_check(y0*4 + $urandom_range(0, 3), x0*4 + $urandom_range(0, 3), "random_origin");
      read_random(3, "random_scan");
    end
  endtask

  initial begin
    test_reset();
    run_cmd(2, 7, 9, 11, 13, 12'h123, "init_clear");
    test_plot();
    test_fill_small();
    test_clear();
    test_clip();
    test_reset_mid_clear();
    test_busy_ignore();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
